// File: rtl/inst_encoder_pkg.sv
// Shared CPU operation set plus the MIPS32 opcode, func and REGIMM-code
// constants that the encoder and the decoder both build on.
package inst_encoder_pkg;

  typedef enum logic [6:0] {
    OP_INVALID,
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR, OP_JALR,
    OP_MOVZ, OP_MOVN, OP_SYSCALL, OP_BREAK, OP_SYNC, OP_MFHI, OP_MTHI,
    OP_MFLO, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ADD, OP_ADDU,
    OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL,
    OP_J, OP_JAL,
    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
    OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
    OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR, OP_LL, OP_SC,
    OP_CACHE,
    OP_MADD, OP_MADDU, OP_MUL, OP_MSUB, OP_MSUBU, OP_CLZ, OP_CLO,
    OP_MFC0, OP_MTC0, OP_TLBR, OP_TLBWI, OP_TLBWR, OP_TLBP, OP_ERET,
    OP_FPU
  } operation_t;

  localparam int OP_COUNT = int'(OP_FPU) + 1;

  // Primary opcodes
  localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J = 6'h02,
    OPC_JAL = 6'h03, OPC_BEQ = 6'h04, OPC_BNE = 6'h05, OPC_BLEZ = 6'h06,
    OPC_BGTZ = 6'h07, OPC_ADDI = 6'h08, OPC_ADDIU = 6'h09, OPC_SLTI = 6'h0A,
    OPC_SLTIU = 6'h0B, OPC_ANDI = 6'h0C, OPC_ORI = 6'h0D, OPC_XORI = 6'h0E,
    OPC_LUI = 6'h0F, OPC_COP0 = 6'h10, OPC_SPECIAL2 = 6'h1C, OPC_LB = 6'h20,
    OPC_LH = 6'h21, OPC_LWL = 6'h22, OPC_LW = 6'h23, OPC_LBU = 6'h24,
    OPC_LHU = 6'h25, OPC_LWR = 6'h26, OPC_SB = 6'h28, OPC_SH = 6'h29,
    OPC_SWL = 6'h2A, OPC_SW = 6'h2B, OPC_SWR = 6'h2E, OPC_CACHE = 6'h2F,
    OPC_LL = 6'h30, OPC_SC = 6'h38;

  // SPECIAL func field
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03,
    FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08,
    FN_JALR = 6'h09, FN_MOVZ = 6'h0A, FN_MOVN = 6'h0B, FN_SYSCALL = 6'h0C,
    FN_BREAK = 6'h0D, FN_SYNC = 6'h0F, FN_MFHI = 6'h10, FN_MTHI = 6'h11,
    FN_MFLO = 6'h12, FN_MTLO = 6'h13, FN_MULT = 6'h18, FN_MULTU = 6'h19,
    FN_DIV = 6'h1A, FN_DIVU = 6'h1B, FN_ADD = 6'h20, FN_ADDU = 6'h21,
    FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25,
    FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  // REGIMM codes (rt field)
  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10,
    RT_BGEZAL = 5'h11;

  // SPECIAL2 func field
  localparam logic [5:0] FN2_MADD = 6'h00, FN2_MADDU = 6'h01, FN2_MUL = 6'h02,
    FN2_MSUB = 6'h04, FN2_MSUBU = 6'h05, FN2_CLZ = 6'h20, FN2_CLO = 6'h21;

  // COP0 rs selectors and CO func field
  localparam logic [4:0] CP0_MF = 5'h00, CP0_MT = 5'h04;
  localparam logic [5:0] CO_TLBR = 6'h01, CO_TLBWI = 6'h02, CO_TLBWR = 6'h06,
    CO_TLBP = 6'h08, CO_ERET = 6'h18;

  typedef enum logic [3:0] {
    FMT_NONE, FMT_SPECIAL, FMT_REGIMM, FMT_ITYPE, FMT_JTYPE, FMT_SPECIAL2,
    FMT_COP0_MF, FMT_COP0_MT, FMT_COP0_CO
  } fmt_t;

  typedef struct packed {
    fmt_t       fmt;
    logic [5:0] code;  // opcode, func or REGIMM code depending on fmt
  } enc_t;

  function automatic enc_t op_info(operation_t op);
    enc_t e;
    e = '{FMT_NONE, 6'h00};
    case (op)
      OP_SLL:     e = '{FMT_SPECIAL, FN_SLL};
      OP_SRL:     e = '{FMT_SPECIAL, FN_SRL};
      OP_SRA:     e = '{FMT_SPECIAL, FN_SRA};
      OP_SLLV:    e = '{FMT_SPECIAL, FN_SLLV};
      OP_SRLV:    e = '{FMT_SPECIAL, FN_SRLV};
      OP_SRAV:    e = '{FMT_SPECIAL, FN_SRAV};
      OP_JR:      e = '{FMT_SPECIAL, FN_JR};
      OP_JALR:    e = '{FMT_SPECIAL, FN_JALR};
      OP_MOVZ:    e = '{FMT_SPECIAL, FN_MOVZ};
      OP_MOVN:    e = '{FMT_SPECIAL, FN_MOVN};
      OP_SYSCALL: e = '{FMT_SPECIAL, FN_SYSCALL};
      OP_BREAK:   e = '{FMT_SPECIAL, FN_BREAK};
      OP_SYNC:    e = '{FMT_SPECIAL, FN_SYNC};
      OP_MFHI:    e = '{FMT_SPECIAL, FN_MFHI};
      OP_MTHI:    e = '{FMT_SPECIAL, FN_MTHI};
      OP_MFLO:    e = '{FMT_SPECIAL, FN_MFLO};
      OP_MTLO:    e = '{FMT_SPECIAL, FN_MTLO};
      OP_MULT:    e = '{FMT_SPECIAL, FN_MULT};
      OP_MULTU:   e = '{FMT_SPECIAL, FN_MULTU};
      OP_DIV:     e = '{FMT_SPECIAL, FN_DIV};
      OP_DIVU:    e = '{FMT_SPECIAL, FN_DIVU};
      OP_ADD:     e = '{FMT_SPECIAL, FN_ADD};
      OP_ADDU:    e = '{FMT_SPECIAL, FN_ADDU};
      OP_SUB:     e = '{FMT_SPECIAL, FN_SUB};
      OP_SUBU:    e = '{FMT_SPECIAL, FN_SUBU};
      OP_AND:     e = '{FMT_SPECIAL, FN_AND};
      OP_OR:      e = '{FMT_SPECIAL, FN_OR};
      OP_XOR:     e = '{FMT_SPECIAL, FN_XOR};
      OP_NOR:     e = '{FMT_SPECIAL, FN_NOR};
      OP_SLT:     e = '{FMT_SPECIAL, FN_SLT};
      OP_SLTU:    e = '{FMT_SPECIAL, FN_SLTU};
      OP_BLTZ:    e = '{FMT_REGIMM, {1'b0, RT_BLTZ}};
      OP_BGEZ:    e = '{FMT_REGIMM, {1'b0, RT_BGEZ}};
      OP_BLTZAL:  e = '{FMT_REGIMM, {1'b0, RT_BLTZAL}};
      OP_BGEZAL:  e = '{FMT_REGIMM, {1'b0, RT_BGEZAL}};
      OP_J:       e = '{FMT_JTYPE, OPC_J};
      OP_JAL:     e = '{FMT_JTYPE, OPC_JAL};
      OP_BEQ:     e = '{FMT_ITYPE, OPC_BEQ};
      OP_BNE:     e = '{FMT_ITYPE, OPC_BNE};
      OP_BLEZ:    e = '{FMT_ITYPE, OPC_BLEZ};
      OP_BGTZ:    e = '{FMT_ITYPE, OPC_BGTZ};
      OP_ADDI:    e = '{FMT_ITYPE, OPC_ADDI};
      OP_ADDIU:   e = '{FMT_ITYPE, OPC_ADDIU};
      OP_SLTI:    e = '{FMT_ITYPE, OPC_SLTI};
      OP_SLTIU:   e = '{FMT_ITYPE, OPC_SLTIU};
      OP_ANDI:    e = '{FMT_ITYPE, OPC_ANDI};
      OP_ORI:     e = '{FMT_ITYPE, OPC_ORI};
      OP_XORI:    e = '{FMT_ITYPE, OPC_XORI};
      OP_LUI:     e = '{FMT_ITYPE, OPC_LUI};
      OP_LB:      e = '{FMT_ITYPE, OPC_LB};
      OP_LH:      e = '{FMT_ITYPE, OPC_LH};
      OP_LWL:     e = '{FMT_ITYPE, OPC_LWL};
      OP_LW:      e = '{FMT_ITYPE, OPC_LW};
      OP_LBU:     e = '{FMT_ITYPE, OPC_LBU};
      OP_LHU:     e = '{FMT_ITYPE, OPC_LHU};
      OP_LWR:     e = '{FMT_ITYPE, OPC_LWR};
      OP_SB:      e = '{FMT_ITYPE, OPC_SB};
      OP_SH:      e = '{FMT_ITYPE, OPC_SH};
      OP_SWL:     e = '{FMT_ITYPE, OPC_SWL};
      OP_SW:      e = '{FMT_ITYPE, OPC_SW};
      OP_SWR:     e = '{FMT_ITYPE, OPC_SWR};
      OP_LL:      e = '{FMT_ITYPE, OPC_LL};
      OP_SC:      e = '{FMT_ITYPE, OPC_SC};
      OP_CACHE:   e = '{FMT_ITYPE, OPC_CACHE};
      OP_MADD:    e = '{FMT_SPECIAL2, FN2_MADD};
      OP_MADDU:   e = '{FMT_SPECIAL2, FN2_MADDU};
      OP_MUL:     e = '{FMT_SPECIAL2, FN2_MUL};
      OP_MSUB:    e = '{FMT_SPECIAL2, FN2_MSUB};
      OP_MSUBU:   e = '{FMT_SPECIAL2, FN2_MSUBU};
      OP_CLZ:     e = '{FMT_SPECIAL2, FN2_CLZ};
      OP_CLO:     e = '{FMT_SPECIAL2, FN2_CLO};
      OP_MFC0:    e = '{FMT_COP0_MF, 6'h00};
      OP_MTC0:    e = '{FMT_COP0_MT, 6'h00};
      OP_TLBR:    e = '{FMT_COP0_CO, CO_TLBR};
      OP_TLBWI:   e = '{FMT_COP0_CO, CO_TLBWI};
      OP_TLBWR:   e = '{FMT_COP0_CO, CO_TLBWR};
      OP_TLBP:    e = '{FMT_COP0_CO, CO_TLBP};
      OP_ERET:    e = '{FMT_COP0_CO, CO_ERET};
      default:    e = '{FMT_NONE, 6'h00};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle between an instruction producer and inst_encoder.
interface inst_encoder_if;
  import inst_encoder_pkg::*;

  logic        in_valid;
  logic        in_ready;
  operation_t  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_sa;
  logic [15:0] in_imm;
  logic [2:0]  in_sel;
  logic [25:0] in_jidx;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_illegal;
  logic [31:0] enc_count;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_sa, in_imm, in_sel, in_jidx,
           flush, out_ready,
    input  in_ready, out_valid, out_inst, out_illegal, enc_count
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_sa, in_imm, in_sel, in_jidx,
           flush, out_ready,
    output in_ready, out_valid, out_inst, out_illegal, enc_count
  );
endinterface

// File: rtl/inst_enc_fifo.sv
// Power-of-two FIFO holding encoded words; flush empties it at the next edge
// and wins over push and pop. The head reads as zero while empty.
module inst_enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             push_en;
  logic             pop_en;

  assign valid   = (count_reg != '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && valid && !flush;

  always_comb begin
    count_next = count_reg;
    case ({push_en, pop_en})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_reg] <= wdata;
  end

  assign rdata = valid ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/inst_encoder.sv
// MIPS32 instruction encoder feeding a small output FIFO.
// Define INST_ENCODER_CP0_EN to encode MFC0/MTC0 and the TLB/ERET CO ops.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           resetn,
  inst_encoder_if.slave bus
);
  enc_t        info;
  logic [31:0] word_next;
  logic        illegal_next;
  logic [32:0] head;
  logic        fifo_valid;
  logic        fifo_full;
  logic        push;
  logic [31:0] enc_count_reg;

  assign info = op_info(bus.in_op);

  always_comb begin
    word_next    = 32'h0;
    illegal_next = 1'b0;
    case (info.fmt)
      FMT_SPECIAL:  word_next = {OPC_SPECIAL, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_sa, info.code};
      FMT_REGIMM:   word_next = {OPC_REGIMM, bus.in_rs, info.code[4:0], bus.in_imm};
      FMT_ITYPE:    word_next = {info.code, bus.in_rs, bus.in_rt, bus.in_imm};
      FMT_JTYPE:    word_next = {info.code, bus.in_jidx};
      FMT_SPECIAL2: word_next = {OPC_SPECIAL2, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, info.code};
`ifdef INST_ENCODER_CP0_EN
      FMT_COP0_MF:  word_next = {OPC_COP0, CP0_MF, bus.in_rt, bus.in_rd, 8'b0, bus.in_sel};
      FMT_COP0_MT:  word_next = {OPC_COP0, CP0_MT, bus.in_rt, bus.in_rd, 8'b0, bus.in_sel};
      FMT_COP0_CO:  word_next = {OPC_COP0, 1'b1, 19'b0, info.code};
`endif
      default:      illegal_next = 1'b1;
    endcase
  end

  // A flush cycle drops the incoming request but still reports ready.
  assign push         = bus.in_valid && !fifo_full && !bus.flush;
  assign bus.in_ready = !fifo_full || bus.flush;

  inst_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (bus.flush),
    .push   (push),
    .wdata  ({illegal_next, word_next}),
    .pop    (bus.out_ready),
    .rdata  (head),
    .valid  (fifo_valid),
    .full   (fifo_full)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   enc_count_reg <= 32'h0;
    else if (push) enc_count_reg <= enc_count_reg + 32'h1;
  end

  assign bus.out_valid   = fifo_valid;
  assign bus.out_inst    = head[31:0];
  assign bus.out_illegal = head[32];
  assign bus.enc_count   = enc_count_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors, FIFO corner
// sequences and a randomized round-trip against a reference decoder.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

`ifdef INST_ENCODER_CP0_EN
  localparam bit CP0 = 1'b1;
`else
  localparam bit CP0 = 1'b0;
`endif
  localparam int DEPTH = 2;

  typedef struct {
    operation_t  op;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [2:0]  sel;
    logic [25:0] jidx;
    logic [31:0] inst;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  inst_encoder_if bus ();
  inst_encoder #(.DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    bus.in_op = v.op; bus.in_rs = v.rs; bus.in_rt = v.rt; bus.in_rd = v.rd;
    bus.in_sa = v.sa; bus.in_imm = v.imm; bus.in_sel = v.sel; bus.in_jidx = v.jidx;
  endtask

  // Reference decoder: instruction word back to operation.
  function automatic operation_t dec(logic [31:0] w);
    operation_t r;
    r = OP_INVALID;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h00: r = OP_SLL;   6'h02: r = OP_SRL;   6'h03: r = OP_SRA;   6'h04: r = OP_SLLV;
        6'h06: r = OP_SRLV;  6'h07: r = OP_SRAV;  6'h08: r = OP_JR;    6'h09: r = OP_JALR;
        6'h0A: r = OP_MOVZ;  6'h0B: r = OP_MOVN;  6'h0C: r = OP_SYSCALL; 6'h0D: r = OP_BREAK;
        6'h0F: r = OP_SYNC;  6'h10: r = OP_MFHI;  6'h11: r = OP_MTHI;  6'h12: r = OP_MFLO;
        6'h13: r = OP_MTLO;  6'h18: r = OP_MULT;  6'h19: r = OP_MULTU; 6'h1A: r = OP_DIV;
        6'h1B: r = OP_DIVU;  6'h20: r = OP_ADD;   6'h21: r = OP_ADDU;  6'h22: r = OP_SUB;
        6'h23: r = OP_SUBU;  6'h24: r = OP_AND;   6'h25: r = OP_OR;    6'h26: r = OP_XOR;
        6'h27: r = OP_NOR;   6'h2A: r = OP_SLT;   6'h2B: r = OP_SLTU;
        default: r = OP_INVALID;
      endcase
      6'h01: case (w[20:16])
        5'h00: r = OP_BLTZ;  5'h01: r = OP_BGEZ;  5'h10: r = OP_BLTZAL; 5'h11: r = OP_BGEZAL;
        default: r = OP_INVALID;
      endcase
      6'h02: r = OP_J;     6'h03: r = OP_JAL;   6'h04: r = OP_BEQ;   6'h05: r = OP_BNE;
      6'h06: r = OP_BLEZ;  6'h07: r = OP_BGTZ;  6'h08: r = OP_ADDI;  6'h09: r = OP_ADDIU;
      6'h0A: r = OP_SLTI;  6'h0B: r = OP_SLTIU; 6'h0C: r = OP_ANDI;  6'h0D: r = OP_ORI;
      6'h0E: r = OP_XORI;  6'h0F: r = OP_LUI;
      6'h10: if (w[25]) case (w[5:0])
        6'h01: r = OP_TLBR; 6'h02: r = OP_TLBWI; 6'h06: r = OP_TLBWR; 6'h08: r = OP_TLBP;
        6'h18: r = OP_ERET;
        default: r = OP_INVALID;
      endcase else if (w[25:21] == 5'd0) r = OP_MFC0;
      else if (w[25:21] == 5'd4) r = OP_MTC0;
      6'h1C: case (w[5:0])
        6'h00: r = OP_MADD;  6'h01: r = OP_MADDU; 6'h02: r = OP_MUL;   6'h04: r = OP_MSUB;
        6'h05: r = OP_MSUBU; 6'h20: r = OP_CLZ;   6'h21: r = OP_CLO;
        default: r = OP_INVALID;
      endcase
      6'h20: r = OP_LB;  6'h21: r = OP_LH;  6'h22: r = OP_LWL; 6'h23: r = OP_LW;
      6'h24: r = OP_LBU; 6'h25: r = OP_LHU; 6'h26: r = OP_LWR; 6'h28: r = OP_SB;
      6'h29: r = OP_SH;  6'h2A: r = OP_SWL; 6'h2B: r = OP_SW;  6'h2E: r = OP_SWR;
      6'h2F: r = OP_CACHE; 6'h30: r = OP_LL; 6'h38: r = OP_SC;
      default: r = OP_INVALID;
    endcase
    return r;
  endfunction

  // Operand fields must land where the word's format puts them.
  function automatic bit fields_ok(logic [31:0] w, vec_t v);
    case (w[31:26])
      6'h00: return w[25:6] == {v.rs, v.rt, v.rd, v.sa};
      6'h01: return (w[25:21] == v.rs) && (w[15:0] == v.imm);
      6'h02, 6'h03: return w[25:0] == v.jidx;
      6'h1C: return w[25:6] == {v.rs, v.rt, v.rd, 5'b0};
      6'h10: return w[25] ? (w[24:6] == 19'b0)
                          : ((w[20:11] == {v.rt, v.rd}) && (w[10:3] == 8'b0) && (w[2:0] == v.sel));
      default: return w[25:0] == {v.rs, v.rt, v.imm};
    endcase
  endfunction

  function automatic bit is_legal(operation_t op);
    bit cp0op;
    cp0op = (op == OP_MFC0) || (op == OP_MTC0) || (op == OP_TLBR) || (op == OP_TLBWI) ||
            (op == OP_TLBWR) || (op == OP_TLBP) || (op == OP_ERET);
    return (op != OP_INVALID) && (op != OP_FPU) && (CP0 || !cp0op);
  endfunction

  vec_t tbl[13];
  vec_t va, vb, vc, v;
  vec_t q[$];
  logic [31:0] exp_count;
  int sweep;
  bit accepted;

  initial begin
    tbl[0]  = '{OP_ADDU,   5'd1,  5'd2,  5'd3,  5'd0, 16'h0000, 3'd0, 26'h0,   32'h0022_1821, 1'b0};
    tbl[1]  = '{OP_J,      5'd0,  5'd0,  5'd0,  5'd0, 16'h0000, 3'd0, 26'h100, 32'h0800_0100, 1'b0};
    tbl[2]  = '{OP_BGEZAL, 5'd4,  5'd7,  5'd0,  5'd0, 16'hFFFE, 3'd0, 26'h0,   32'h0491_FFFE, 1'b0};
    tbl[3]  = '{OP_SLL,    5'd0,  5'd6,  5'd5,  5'd7, 16'h0000, 3'd0, 26'h0,   32'h0006_29C0, 1'b0};
    tbl[4]  = '{OP_LUI,    5'd0,  5'd8,  5'd0,  5'd0, 16'h1234, 3'd0, 26'h0,   32'h3C08_1234, 1'b0};
    tbl[5]  = '{OP_MUL,    5'd1,  5'd2,  5'd3,  5'd5, 16'h0000, 3'd0, 26'h0,   32'h7022_1802, 1'b0};
    tbl[6]  = '{OP_CACHE,  5'd4,  5'd1,  5'd0,  5'd0, 16'h0010, 3'd0, 26'h0,   32'hBC81_0010, 1'b0};
    tbl[7]  = '{OP_SW,     5'd29, 5'd31, 5'd0,  5'd0, 16'hFFFC, 3'd0, 26'h0,   32'hAFBF_FFFC, 1'b0};
    tbl[8]  = '{OP_ERET,   5'd3,  5'd0,  5'd0,  5'd0, 16'h0000, 3'd0, 26'h0,   CP0 ? 32'h4200_0018 : 32'h0, !CP0};
    tbl[9]  = '{OP_MTC0,   5'd0,  5'd9,  5'd12, 5'd0, 16'h0000, 3'd2, 26'h0,   CP0 ? 32'h4089_6002 : 32'h0, !CP0};
    tbl[10] = '{OP_MFC0,   5'd0,  5'd3,  5'd15, 5'd0, 16'h0000, 3'd0, 26'h0,   CP0 ? 32'h4003_7800 : 32'h0, !CP0};
    tbl[11] = '{OP_INVALID,5'd1,  5'd2,  5'd3,  5'd4, 16'hAAAA, 3'd1, 26'h0,   32'h0, 1'b1};
    tbl[12] = '{OP_FPU,    5'd1,  5'd2,  5'd3,  5'd4, 16'h5555, 3'd1, 26'h0,   32'h0, 1'b1};

    resetn = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    drive(tbl[0]);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    chk("rst_enc_count", bus.enc_count, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    exp_count = 32'h0;

    // Directed vectors, one at a time
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i]); bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0; exp_count++;
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_inst", i), bus.out_inst, tbl[i].inst);
      chk($sformatf("vec%0d_illegal", i), 32'(bus.out_illegal), 32'(tbl[i].ill));
      chk($sformatf("vec%0d_count", i), bus.enc_count, exp_count);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      chk($sformatf("vec%0d_popped", i), 32'(bus.out_valid), 32'd0);
      $display("vector %0d op=%s inst=%h illegal=%0b", i, tbl[i].op.name(), tbl[i].inst, tbl[i].ill);
    end

    // Backpressure: third request refused until one pop frees a slot
    va = tbl[0]; vb = tbl[1]; vc = tbl[2];
    @(negedge clk); drive(va); bus.in_valid = 1'b1; #1;
    chk("bp_ready1", 32'(bus.in_ready), 32'd1);
    @(negedge clk); drive(vb); #1;
    chk("bp_ready2", 32'(bus.in_ready), 32'd1);
    @(negedge clk); drive(vc); #1;
    chk("bp_ready3", 32'(bus.in_ready), 32'd0);
    chk("bp_count2", bus.enc_count, exp_count + 32'd2);
    bus.out_ready = 1'b1;
    @(negedge clk); bus.out_ready = 1'b0; #1;
    chk("bp_ready_after_pop", 32'(bus.in_ready), 32'd1);
    chk("bp_head_b", bus.out_inst, vb.inst);
    @(negedge clk); bus.in_valid = 1'b0; #1;
    chk("bp_full_again", 32'(bus.in_ready), 32'd0);
    chk("bp_count3", bus.enc_count, exp_count + 32'd3);
    exp_count += 32'd3;
    bus.out_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_head_c", bus.out_inst, vc.inst);
    @(negedge clk); bus.out_ready = 1'b0; #1;
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    $display("backpressure sequence done count=%h", bus.enc_count);

    // Flush of a full FIFO with a competing request
    @(negedge clk); drive(va); bus.in_valid = 1'b1;
    @(negedge clk); drive(vb);
    @(negedge clk); drive(vc); bus.flush = 1'b1; #1;
    chk("fl_ready_during_flush", 32'(bus.in_ready), 32'd1);
    exp_count += 32'd2;
    @(negedge clk); bus.flush = 1'b0; bus.in_valid = 1'b0; #1;
    chk("fl_empty", 32'(bus.out_valid), 32'd0);
    chk("fl_inst_zero", bus.out_inst, 32'h0);
    chk("fl_count", bus.enc_count, exp_count);
    $display("flush sequence done count=%h", bus.enc_count);

    // Reset mid-operation discards queued words
    @(negedge clk); drive(vb); bus.in_valid = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0; #2;
    resetn = 1'b0; #1;
    chk("mr_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_count", bus.enc_count, 32'h0);
    @(negedge clk); resetn = 1'b1; drive(va); bus.in_valid = 1'b1;
    @(negedge clk); bus.in_valid = 1'b0; #1;
    chk("mr_first_accept", bus.out_inst, va.inst);
    chk("mr_count1", bus.enc_count, 32'h1);
    bus.out_ready = 1'b1;
    @(negedge clk); bus.out_ready = 1'b0;
    $display("mid-run reset sequence done");

    // Counter wrap
    @(negedge clk); #1;
    force dut.enc_count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.enc_count_reg;
    @(negedge clk); drive(va); bus.in_valid = 1'b1; #1;
    chk("wrap_preset", bus.enc_count, 32'hFFFF_FFFF);
    @(negedge clk); bus.in_valid = 1'b0; #1;
    chk("wrap_zero", bus.enc_count, 32'h0);
    bus.out_ready = 1'b1;
    @(negedge clk); bus.out_ready = 1'b0;
    $display("wrap sequence done count=%h", bus.enc_count);

    // Randomized round-trip against the scoreboard
    exp_count = 32'h0;
    sweep = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      v.op   = (sweep < OP_COUNT) ? operation_t'(sweep) : operation_t'($urandom_range(0, OP_COUNT - 1));
      v.rs   = 5'($urandom); v.rt = 5'($urandom); v.rd = 5'($urandom); v.sa = 5'($urandom);
      v.imm  = 16'($urandom); v.sel = 3'($urandom); v.jidx = 26'($urandom);
      v.inst = 32'h0; v.ill = !is_legal(v.op);
      drive(v);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = (sweep >= OP_COUNT) && ($urandom_range(0, 31) == 0);
      #1;
      chk("rnd_in_ready", 32'(bus.in_ready), 32'((q.size() < DEPTH) || bus.flush));
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("rnd_count", bus.enc_count, exp_count);
      if (q.size() != 0) begin
        if (q[0].ill) begin
          chk("rnd_illegal_inst", bus.out_inst, 32'h0);
          chk("rnd_illegal_flag", 32'(bus.out_illegal), 32'd1);
        end else begin
          chk("rnd_roundtrip", 32'(dec(bus.out_inst)), 32'(q[0].op));
          chk("rnd_fields", 32'(fields_ok(bus.out_inst, q[0])), 32'd1);
          chk("rnd_legal_flag", 32'(bus.out_illegal), 32'd0);
        end
      end else begin
        chk("rnd_empty_inst", bus.out_inst, 32'h0);
        chk("rnd_empty_illegal", 32'(bus.out_illegal), 32'd0);
      end
      if (bus.flush) begin
        q.delete();
      end else begin
        accepted = bus.in_valid && (q.size() < DEPTH);
        if (bus.out_ready && q.size() != 0) void'(q.pop_front());
        if (accepted) begin
          q.push_back(v);
          exp_count++;
          sweep++;
        end
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    $display("random phase done ops_swept=%0d count=%h", sweep, exp_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter: DEPTH, 2, output FIFO entries (power of two, at least 2).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  in  1  request carries an operation to encode.
REQ-005 SHALL have port: in_ready  out  1  encoder accepts a request this cycle.
REQ-006 SHALL have port: in_op  in  operation_t  operation to encode.
REQ-007 SHALL have ports: in_rs, in_rt, in_rd, in_sa  in  5 each  register and shift fields.
REQ-008 SHALL have ports: in_imm  in  16; in_sel  in  3; in_jidx  in  26.
REQ-009 SHALL have port: flush  in  1  discard all queued words.
REQ-010 SHALL have port: out_valid  out  1  FIFO head valid.
REQ-011 SHALL have port: out_ready  in  1  consumer takes the head.
REQ-012 SHALL have port: out_inst  out  32  encoded MIPS32 word at the head.
REQ-013 SHALL have port: out_illegal  out  1  head op not encodable.
REQ-014 SHALL have port: enc_count  out  32  count of accepted requests.

Function
REQ-015 SHALL accept a request on a cycle with in_valid && in_ready; in_ready = !full, independent of out_ready.
REQ-016 SHALL pop the head on out_valid && out_ready; push and pop in the same cycle are both honoured when not full.
REQ-017 SHALL present an accepted word at the head exactly 1 cycle after acceptance when the FIFO was empty (registered encode, no combinational in-to-out path).
REQ-018 SHALL encode SPECIAL ops as {000000, rs, rt, rd, sa, func}, and REGIMM ops as {000001, rs, code, imm}, with code in the rt field.
REQ-019 SHALL encode I-type ops as {op, rs, rt, imm} and J/JAL as {op, jidx}.
REQ-020 SHALL encode SPECIAL2 ops as {011100, rs, rt, rd, 00000, func} and CACHE as {101111, rs, rt, imm}.
REQ-021 SHALL use the MIPS32 opcode, func and rt-code values for every op in operation_t, identical to the decode map.
REQ-022 SHALL, for OP_INVALID, OP_FPU and any op with no encoding, queue out_inst=32'h0 with out_illegal=1 and still count the request.
REQ-023 SHALL zero out_inst and out_illegal whenever out_valid=0.
REQ-024 SHALL, on flush, empty the FIFO at the next edge; a request in the same cycle is dropped and not counted; flush takes priority over push and pop.
REQ-025 SHALL have in_ready=1 during a flush cycle.
REQ-026 SHALL increment enc_count per accepted request, wrapping 32'hFFFF_FFFF to 0.
REQ-027 SHALL wrap the FIFO read and write pointers modulo DEPTH and hold an occupancy count of 0..DEPTH.

Reset
REQ-028 SHALL, on resetn low, clear all pointers and the occupancy count, and set out_valid=0, out_inst=0, out_illegal=0, enc_count=0 and in_ready=1.
REQ-029 SHALL discard any queued words when resetn asserts mid-operation; the first acceptance is possible on the first edge after release.

Configuration
REQ-030 SHALL, with INST_ENCODER_CP0_EN defined, encode MFC0/MTC0 as {010000, 00000|00100, rt, rd, 00000000, sel}, and TLBR/TLBWI/TLBWR/TLBP/ERET as {010000, 1, 19'b0, func}.
REQ-031 SHALL, without INST_ENCODER_CP0_EN, treat those seven ops per REQ-022.

Structure
REQ-032 SHALL take operation_t and the opcode, func and REGIMM-code constants from the shared cpu package, so that encoder and decoder share one table.
REQ-033 SHALL place the FIFO in one sub-module, inst_enc_fifo (DEPTH, 33-bit payload); the encode logic stays in the top.

Verification
REQ-034 SHALL cover: OP_ADDU, rs=1, rt=2, rd=3 -> out_inst=32'h0022_1821 one cycle later, out_illegal=0.
REQ-035 SHALL cover: OP_J, jidx=26'h0000100 -> out_inst=32'h0800_0100; OP_BGEZAL, rs=4, imm=16'hFFFE -> 32'h0491_FFFE.
REQ-036 SHALL cover: out_ready=0 with 3 requests -> 2 accepted, in_ready=0 on the third; one pop -> the third is accepted next cycle.
REQ-037 SHALL cover: flush with a full FIFO plus in_valid -> out_valid=0 next cycle and enc_count unchanged by the flush-cycle request.
REQ-038 SHALL cover: OP_ERET with the macro -> 32'h4200_0018; without it -> 32'h0 and out_illegal=1.
REQ-039 SHALL cover: a random round-trip of every legal op -> inst_decoder(out_inst) equals in_op; enc_count preset near wrap -> rolls to 0.
